// File: rtl/fpnew_opgroup_issue_sched_if.sv
// Bundle of the requester, opgroup-issue and result-return signals
// shared by the issue scheduler and its environment.
interface fpnew_opgroup_issue_sched_if #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RspWidth       = 38,
    parameter int unsigned FmtBits        = 3,
    parameter int unsigned MaxOutstanding = 8
);
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    logic                               flush_i;
    logic [NumReq-1:0]                  req_valid_i;
    logic [NumReq-1:0]                  req_ready_o;
    logic [NumReq-1:0][ReqWidth-1:0]    req_data_i;
    logic [NumReq-1:0][FmtBits-1:0]     req_fmt_i;
    logic                               fpu_valid_o;
    logic                               fpu_ready_i;
    logic [ReqWidth-1:0]                fpu_data_o;
    logic [FmtBits-1:0]                 fpu_fmt_o;
    logic                               fpu_flush_o;
    logic                               fpu_out_valid_i;
    logic                               fpu_out_ready_o;
    logic [RspWidth-1:0]                fpu_rsp_i;
    logic [NumReq-1:0]                  rsp_valid_o;
    logic [NumReq-1:0]                  rsp_ready_i;
    logic [RspWidth-1:0]                rsp_data_o;
    logic [CntW-1:0]                    outstanding_o;
    logic                               busy_o;
    logic                               err_o;

    // Environment side: requesters plus the opgroup block.
    modport master (
        output flush_i, req_valid_i, req_data_i, req_fmt_i, fpu_ready_i,
               fpu_out_valid_i, fpu_rsp_i, rsp_ready_i,
        input  req_ready_o, fpu_valid_o, fpu_data_o, fpu_fmt_o, fpu_flush_o,
               fpu_out_ready_o, rsp_valid_o, rsp_data_o, outstanding_o, busy_o, err_o
    );

    // Scheduler side.
    modport slave (
        input  flush_i, req_valid_i, req_data_i, req_fmt_i, fpu_ready_i,
               fpu_out_valid_i, fpu_rsp_i, rsp_ready_i,
        output req_ready_o, fpu_valid_o, fpu_data_o, fpu_fmt_o, fpu_flush_o,
               fpu_out_ready_o, rsp_valid_o, rsp_data_o, outstanding_o, busy_o, err_o
    );
endinterface

// File: rtl/fpnew_opgroup_issue_sched.sv
// Round-robin issue of NumReq requesters into one shared opgroup block.
// Issued requester IDs go into an in-flight FIFO so that results can be routed back
// to their owners. New ops issue only while their format matches the ops already in
// flight, so results always come back in issue order.
module fpnew_opgroup_issue_sched #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RspWidth       = 38,
    parameter int unsigned FmtBits        = 3,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    fpnew_opgroup_issue_sched_if.slave bus
);
    localparam int unsigned IdW  = $clog2(NumReq);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    logic [IdW-1:0]     id_mem [MaxOutstanding];
    logic [PtrW-1:0]    wr_ptr, rd_ptr;
    logic [CntW-1:0]    count, count_next;
    logic [IdW-1:0]     rr_ptr;
    logic [FmtBits-1:0] cur_fmt;
    logic               busy_q;

    logic [NumReq-1:0]  eligible;
    logic               found;
    logic [IdW-1:0]     grant;
    logic [IdW-1:0]     head;
    logic               empty, push, pop;

    logic               fpu_valid, out_ready, err;
    logic [NumReq-1:0]  req_ready, rsp_valid;
    logic [ReqWidth-1:0] fpu_data;
    logic [FmtBits-1:0] fpu_fmt;
    logic [RspWidth-1:0] rsp_data;

    assign empty      = (count == '0);
    assign head       = id_mem[rd_ptr];
    assign count_next = count + CntW'(push) - CntW'(pop);

    // A requester may issue only when there is room and its format matches what is in flight.
    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = bus.req_valid_i[i] && (count < CntW'(MaxOutstanding)) &&
                          (empty || (bus.req_fmt_i[i] == cur_fmt));
        end
    end

    // First eligible requester at or after rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(rr_ptr) + k) % NumReq;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = IdW'(idx);
            end
        end
    end

    // Issue and return handshakes; everything is held quiet in reset and flush.
    always_comb begin
        fpu_valid = found && !bus.flush_i && !rst_i;
        push      = fpu_valid && bus.fpu_ready_i;
        req_ready = '0;
        rsp_valid = '0;
        fpu_data  = '0;
        fpu_fmt   = '0;
        rsp_data  = '0;
        out_ready = 1'b0;
        err       = 1'b0;
        pop       = 1'b0;
        if (!rst_i) begin
            fpu_data = bus.req_data_i[grant];
            fpu_fmt  = bus.req_fmt_i[grant];
            rsp_data = bus.fpu_rsp_i;
            if (push) req_ready[grant] = 1'b1;
            if (empty) begin
                // Nobody owns this result: swallow it and flag it.
                out_ready = 1'b1;
                err       = bus.fpu_out_valid_i;
            end else begin
                out_ready = bus.flush_i || bus.rsp_ready_i[head];
                if (!bus.flush_i) rsp_valid[head] = bus.fpu_out_valid_i;
                pop = !bus.flush_i && bus.fpu_out_valid_i && out_ready;
            end
        end
    end

    // In-flight ID storage; entries are only read while the FIFO holds them.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= grant;
    end

    // FIFO pointers, occupancy, round-robin pointer and in-flight format.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr_ptr  <= '0;
            cur_fmt <= '0;
            busy_q  <= 1'b0;
        end else if (bus.flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr_ptr  <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cur_fmt <= bus.req_fmt_i[grant];
                rr_ptr  <= (grant == IdW'(NumReq - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            busy_q <= (count_next != '0);
        end
    end

    assign bus.fpu_valid_o     = fpu_valid;
    assign bus.req_ready_o     = req_ready;
    assign bus.fpu_data_o      = fpu_data;
    assign bus.fpu_fmt_o       = fpu_fmt;
    assign bus.fpu_flush_o     = bus.flush_i;
    assign bus.fpu_out_ready_o = out_ready;
    assign bus.rsp_valid_o     = rsp_valid;
    assign bus.rsp_data_o      = rsp_data;
    assign bus.outstanding_o   = count;
    assign bus.busy_o          = busy_q;
    assign bus.err_o           = err;
endmodule

// File: tb/tb_fpnew_opgroup_issue_sched.sv
// Bench for the opgroup issue scheduler: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the in-flight owners.
module tb_fpnew_opgroup_issue_sched;
    localparam int NR = 4, RQW = 64, RSW = 38, FB = 3, MAXO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0, miscompares = 0;

    // Reference model: owners of in-flight ops in issue order, rr start point, in-flight format.
    int   q[$];
    int   rr = 0, cur_fmt = 0;
    bit   m_push, m_pop;
    int   m_g;
    logic [RSW-1:0] rsp_k = 38'h1ADEADBEEF;

    fpnew_opgroup_issue_sched_if #(.NumReq(NR), .ReqWidth(RQW), .RspWidth(RSW),
        .FmtBits(FB), .MaxOutstanding(MAXO)) bus();

    fpnew_opgroup_issue_sched #(.NumReq(NR), .ReqWidth(RQW), .RspWidth(RSW),
        .FmtBits(FB), .MaxOutstanding(MAXO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush_i = 1'b0; bus.req_valid_i = '0; bus.fpu_ready_i = 1'b0;
        bus.fpu_out_valid_i = 1'b0; bus.rsp_ready_i = '1;
        for (int i = 0; i < NR; i++) bus.req_fmt_i[i] = '0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) bus.req_data_i[i] = {$urandom, $urandom};
        bus.fpu_rsp_i = RSW'({$urandom, $urandom});
    endtask

    // Settle combinational outputs, predict them from the model, and compare.
    task automatic settle();
        bit any = 0;
        int g = 0;
        bit exp_v, exp_or, exp_err;
        logic [NR-1:0] erdy, erv;
        #1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr + k) % NR;
            if (!any && bus.req_valid_i[idx] && q.size() < MAXO &&
                (q.size() == 0 || int'(bus.req_fmt_i[idx]) == cur_fmt)) begin
                any = 1; g = idx;
            end
        end
        exp_v  = any && !bus.flush_i;
        m_push = exp_v && bus.fpu_ready_i;
        m_g    = g;
        erdy   = '0;
        if (m_push) erdy[g] = 1'b1;
        chk("fpu_valid", 64'(bus.fpu_valid_o), 64'(exp_v));
        chk("req_ready", 64'(bus.req_ready_o), 64'(erdy));
        if (exp_v) begin
            chk("fpu_data", 64'(bus.fpu_data_o), 64'(bus.req_data_i[g]));
            chk("fpu_fmt", 64'(bus.fpu_fmt_o), 64'(bus.req_fmt_i[g]));
        end
        erv = '0;
        exp_err = 0;
        if (q.size() == 0) begin
            exp_or = 1; exp_err = bus.fpu_out_valid_i; m_pop = 0;
        end else begin
            exp_or = bus.flush_i || bus.rsp_ready_i[q[0]];
            if (!bus.flush_i && bus.fpu_out_valid_i) erv[q[0]] = 1'b1;
            m_pop = !bus.flush_i && bus.fpu_out_valid_i && exp_or;
        end
        chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(erv));
        chk("out_ready", 64'(bus.fpu_out_ready_o), 64'(exp_or));
        chk("err", 64'(bus.err_o), 64'(exp_err));
        chk("rsp_data", 64'(bus.rsp_data_o), 64'(bus.fpu_rsp_i));
        chk("fpu_flush", 64'(bus.fpu_flush_o), 64'(bus.flush_i));
        chk("outstanding", 64'(bus.outstanding_o), 64'(q.size()));
        chk("busy", 64'(bus.busy_o), 64'(q.size() != 0));
    endtask

    // Advance the model across the clock edge using its own predicted handshakes.
    task automatic tick();
        @(posedge clk);
        if (bus.flush_i) begin
            q.delete(); rr = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(m_g);
                cur_fmt = int'(bus.req_fmt_i[m_g]);
                rr = (m_g + 1) % NR;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle(); tick();
    endtask

    initial begin
        // Reset with busy-looking inputs: every output must stay quiet.
        idle(); rand_data();
        bus.req_valid_i = '1; bus.fpu_ready_i = 1'b1; bus.fpu_out_valid_i = 1'b1;
        @(negedge clk); #1;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'(0));
        chk("rst_fpu_valid", 64'(bus.fpu_valid_o), 64'(0));
        chk("rst_fpu_data", 64'(bus.fpu_data_o), 64'(0));
        chk("rst_fpu_fmt", 64'(bus.fpu_fmt_o), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_out_ready", 64'(bus.fpu_out_ready_o), 64'(0));
        chk("rst_rsp_data", 64'(bus.rsp_data_o), 64'(0));
        chk("rst_outstanding", 64'(bus.outstanding_o), 64'(0));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_err", 64'(bus.err_o), 64'(0));
        rst = 1'b0; idle();
        @(negedge clk);
        step(); step();

        // Round robin with a common format, then in-order returns.
        for (int i = 0; i < NR; i++) begin bus.req_valid_i[i] = 1'b1; bus.req_fmt_i[i] = FB'(2); end
        bus.fpu_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_data(); settle();
            chk("rr_grant", 64'(bus.req_ready_o), 64'(NR'(1) << (k % NR)));
            tick();
        end
        idle(); bus.fpu_out_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_data(); settle();
            chk("rr_rsp", 64'(bus.rsp_valid_o), 64'(NR'(1) << (k % NR)));
            tick();
        end

        // Format fence: fmt 1 waits behind an in-flight fmt 0 op.
        idle(); bus.req_valid_i[0] = 1'b1; bus.fpu_ready_i = 1'b1;
        settle(); chk("fence_issue0", 64'(bus.req_ready_o), 64'(4'b0001)); tick();
        bus.req_valid_i = '0; bus.req_valid_i[1] = 1'b1; bus.req_fmt_i[1] = FB'(1);
        for (int k = 0; k < 3; k++) begin
            bus.fpu_out_valid_i = (k == 2);
            settle(); chk("fence_stall", 64'(bus.req_ready_o), 64'(0)); tick();
        end
        bus.fpu_out_valid_i = 1'b0;
        settle(); chk("fence_go", 64'(bus.req_ready_o), 64'(4'b0010)); tick();
        bus.req_valid_i = '0; bus.fpu_out_valid_i = 1'b1;
        settle(); chk("fence_ret", 64'(bus.rsp_valid_o), 64'(4'b0010)); tick();

        // In-flight limit: 8 issued, 9th blocked, one pop reopens issue a cycle later.
        idle(); bus.req_valid_i[0] = 1'b1; bus.req_fmt_i[0] = FB'(5); bus.fpu_ready_i = 1'b1;
        for (int k = 0; k < MAXO; k++) begin
            settle(); chk("full_issue", 64'(bus.req_ready_o), 64'(1)); tick();
        end
        bus.fpu_out_valid_i = 1'b1;
        settle(); chk("full_block", 64'(bus.req_ready_o), 64'(0));
        chk("full_cnt8", 64'(bus.outstanding_o), 64'(8)); tick();
        bus.fpu_out_valid_i = 1'b0;
        settle(); chk("full_cnt7", 64'(bus.outstanding_o), 64'(7));
        chk("full_resume", 64'(bus.req_ready_o), 64'(1)); tick();
        bus.req_valid_i = '0;
        settle(); chk("full_cnt8b", 64'(bus.outstanding_o), 64'(8)); tick();
        bus.fpu_out_valid_i = 1'b1;
        repeat (MAXO) step();
        bus.fpu_out_valid_i = 1'b0; step();

        // Response backpressure on the head owner.
        idle(); bus.req_valid_i[2] = 1'b1; bus.req_fmt_i[2] = FB'(3); bus.fpu_ready_i = 1'b1;
        settle(); chk("bp_issue", 64'(bus.req_ready_o), 64'(4'b0100)); tick();
        bus.req_valid_i = '0; bus.fpu_out_valid_i = 1'b1; bus.rsp_ready_i = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            rand_data(); settle();
            chk("bp_hold_ready", 64'(bus.fpu_out_ready_o), 64'(0));
            chk("bp_hold_cnt", 64'(bus.outstanding_o), 64'(1));
            chk("bp_hold_rv", 64'(bus.rsp_valid_o), 64'(4'b0100));
            tick();
        end
        bus.rsp_ready_i = '1; bus.fpu_rsp_i = rsp_k;
        settle(); chk("bp_pop_ready", 64'(bus.fpu_out_ready_o), 64'(1));
        chk("bp_data", 64'(bus.rsp_data_o), 64'(38'h1ADEADBEEF)); tick();
        bus.fpu_out_valid_i = 1'b0;
        settle(); chk("bp_cnt0", 64'(bus.outstanding_o), 64'(0)); tick();

        // Flush with 3 in flight, then a stray result.
        idle(); bus.req_valid_i[3] = 1'b1; bus.fpu_ready_i = 1'b1;
        repeat (3) step();
        bus.flush_i = 1'b1; bus.fpu_out_valid_i = 1'b1;
        settle();
        chk("fl_fpu_valid", 64'(bus.fpu_valid_o), 64'(0));
        chk("fl_req_ready", 64'(bus.req_ready_o), 64'(0));
        chk("fl_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("fl_out_ready", 64'(bus.fpu_out_ready_o), 64'(1));
        chk("fl_cnt3", 64'(bus.outstanding_o), 64'(3));
        tick();
        bus.flush_i = 1'b0; bus.req_valid_i = '0;
        settle();
        chk("fl_cnt0", 64'(bus.outstanding_o), 64'(0));
        chk("stray_err", 64'(bus.err_o), 64'(1));
        chk("stray_rv", 64'(bus.rsp_valid_o), 64'(0));
        tick();
        bus.fpu_out_valid_i = 1'b0;
        settle(); chk("err_clear", 64'(bus.err_o), 64'(0)); tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                bus.req_valid_i[i] = 1'($urandom_range(0, 1));
                bus.req_fmt_i[i]   = FB'($urandom_range(0, 1));
                bus.rsp_ready_i[i] = 1'($urandom_range(0, 3) != 0);
            end
            rand_data();
            bus.fpu_ready_i     = ($urandom_range(0, 3) != 0);
            bus.fpu_out_valid_i = 1'($urandom_range(0, 1));
            bus.flush_i         = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fpnew_opgroup_issue_sched.md
Name: fpnew_opgroup_issue_sched

Overview:
- Shares one opgroup block between NumReq independent requesters (e.g. lanes or harts) through a round-robin issue arbiter.
- Records the requester ID of every issued op in an in-flight ID FIFO and routes each returning result to its owner.
- The opgroup block can complete ops of different formats out of order, because per-format pipe depths differ. The scheduler therefore only lets a new op issue while in flight if its format matches the ops already in flight. This guarantees in-order return.

Parameters:
- NumReq, 4, number of requesters (2..8).
- ReqWidth, 64, opaque request payload bits (operands, op, rnd_mode) forwarded unchanged.
- RspWidth, 38, opaque response payload bits (result, status, ext_bit).
- FmtBits, 3, width of the destination-format field.
- MaxOutstanding, 8, depth of the ID FIFO and the in-flight limit; power of two, >=2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  synchronous flush of all in-flight tracking
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester request accepted
- req_data_i  in  NumReq*ReqWidth  request payloads
- req_fmt_i  in  NumReq*FmtBits  destination format per request
- fpu_valid_o  out  1  issue valid to the opgroup block
- fpu_ready_i  in  1  opgroup block input ready
- fpu_data_o  out  ReqWidth  payload of the granted requester
- fpu_fmt_o  out  FmtBits  format of the granted requester
- fpu_flush_o  out  1  equals flush_i
- fpu_out_valid_i  in  1  result valid from the opgroup block
- fpu_out_ready_o  out  1  result ready to the opgroup block
- fpu_rsp_i  in  RspWidth  result payload
- rsp_valid_o  out  NumReq  per-requester response valid
- rsp_ready_i  in  NumReq  per-requester response ready
- rsp_data_o  out  RspWidth  response payload, broadcast to all requesters
- outstanding_o  out  $clog2(MaxOutstanding)+1  count of ops in flight
- busy_o  out  1  outstanding_o != 0
- err_o  out  1  one-cycle pulse when an unexpected result arrives

Behaviour:
- Reset (asynchronous assert, rst_i=1):
  - ID FIFO empty, count=0, rr pointer=0, cur_fmt=0.
  - All valid and ready outputs are 0, err_o=0, data outputs are 0.
- Eligibility: requester i is eligible when req_valid_i[i] && count<MaxOutstanding && (count==0 || req_fmt_i[i]==cur_fmt).
- Arbitration:
  - Purely combinational, zero-latency round robin.
  - Grant goes to the first eligible requester starting at rr_ptr and wrapping modulo NumReq.
  - fpu_valid_o = any eligible. fpu_data_o and fpu_fmt_o come from the granted requester.
  - req_ready_o[g] = fpu_ready_i && fpu_valid_o; all other req_ready_o bits are 0.
  - fpu_valid_o must not depend on fpu_ready_i.
- Issue handshake (fpu_valid_o && fpu_ready_i):
  - Push g into the ID FIFO.
  - cur_fmt <= granted format.
  - rr_ptr <= (g+1) mod NumReq.
  - rr_ptr holds whenever no handshake occurs.
- Return path:
  - When the FIFO is non-empty, head = FIFO head ID.
  - rsp_valid_o[head] = fpu_out_valid_i; all other rsp_valid_o bits are 0.
  - fpu_out_ready_o = rsp_ready_i[head].
  - rsp_data_o = fpu_rsp_i.
  - On handshake, pop the FIFO.
- Unexpected result (fpu_out_valid_i while the FIFO is empty):
  - fpu_out_ready_o=1, so the result is dropped.
  - No rsp_valid_o bit is asserted.
  - err_o=1 for that cycle.
- Simultaneous push and pop: count is unchanged; FIFO pointers wrap modulo MaxOutstanding.
- Full FIFO: count==MaxOutstanding gives no eligible requester; a pop in the same cycle does not unblock issue until the next cycle.
- Format change: a requester with a different fmt waits until count reaches 0. The RR grant skips it in the meantime, so other matching requesters may keep issuing; this starvation is accepted.
- Flush (flush_i=1, checked before reset release is irrelevant):
  - Next cycle: FIFO empty, count=0, rr_ptr=0.
  - During the flush cycle all req_ready_o, fpu_valid_o and rsp_valid_o are forced 0, and fpu_out_ready_o=1.
- Reset mid-operation: in-flight tracking is lost; the downstream block must be reset together with this block.
- outstanding_o and busy_o are registered from count.

Test Plan:
- Reset then idle: rst_i pulse with no requests -> all outputs 0, busy_o=0, outstanding_o=0.
- Round robin, same fmt: all 4 requesters valid with fmt=2, fpu_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; results returned in order reach rsp_valid_o[0],[1],[2],[3],[0].
- Format fence: req0 fmt=0 issued; req1 fmt=1 valid while a 3-cycle-latency result is pending -> req1 stalls until the result pops, then issues on the cycle after count reaches 0.
- Full limit: MaxOutstanding=8 issued with no returns -> 9th request sees req_ready_o=0; one return pops -> issue resumes the following cycle, and outstanding_o goes 8, 7, 8.
- Backpressure: rsp_ready_i[head]=0 for 5 cycles while fpu_out_valid_i=1 -> fpu_out_ready_o=0 and the FIFO head holds; on release one pop occurs with rsp_data_o equal to fpu_rsp_i.
- Flush and error: flush_i with 3 ops in flight -> count=0 next cycle; a subsequent stray fpu_out_valid_i -> err_o=1 for one cycle and no rsp_valid_o bit asserted.
